// File: rtl/bg_fb_writer_pkg.sv
// bg_fb_writer_pkg: framebuffer geometry, bus widths and writer FSM state encoding shared by reader and writer
package bg_fb_writer_pkg;
  localparam int FB_WIDTH = 400;
  localparam int FB_HEIGHT = 300;
  localparam int FB_ADDR_W = 20;
  localparam int FB_PIX_W = 4;
  localparam int FB_COORD_W = 9;
  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_IDLE = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;
endpackage

// File: rtl/bg_fb_writer_if.sv
// bg_fb_writer_if: rectangle command handshake plus framebuffer write port; master = game logic, slave = writer
interface bg_fb_writer_if;
  import bg_fb_writer_pkg::*;
  logic cmd_valid;
  logic cmd_ready;
  logic [FB_COORD_W-1:0] cmd_x0;
  logic [FB_COORD_W-1:0] cmd_y0;
  logic [FB_COORD_W-1:0] cmd_x1;
  logic [FB_COORD_W-1:0] cmd_y1;
  logic [FB_PIX_W-1:0] cmd_color;
  logic wr_en;
  logic [FB_ADDR_W-1:0] wr_addr;
  logic [FB_PIX_W-1:0] wr_data;
  logic busy;
  logic done;
  logic err;
  modport master(output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
                 input cmd_ready, wr_en, wr_addr, wr_data, busy, done, err);
  modport slave(input cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
                output cmd_ready, wr_en, wr_addr, wr_data, busy, done, err);
endinterface

// File: rtl/bg_fb_writer_fb_rect_scanner.sv
// fb_rect_scanner: raster x/y counters with row_base; ports pclk, rst, load (x0,y0,x1,y1), step -> addr (registered), last
module fb_rect_scanner
  import bg_fb_writer_pkg::*;
#(
  parameter int W = FB_WIDTH,
  parameter int H = FB_HEIGHT
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [FB_COORD_W-1:0] x0,
  input  logic [FB_COORD_W-1:0] y0,
  input  logic [FB_COORD_W-1:0] x1,
  input  logic [FB_COORD_W-1:0] y1,
  output logic [FB_ADDR_W-1:0]  addr,
  output logic                  last
);
  localparam logic [FB_COORD_W-1:0] XM = FB_COORD_W'(W - 1);
  localparam logic [FB_COORD_W-1:0] YM = FB_COORD_W'(H - 1);
  localparam logic [FB_ADDR_W-1:0] WA = FB_ADDR_W'(W);
  logic [FB_COORD_W-1:0] xs, xe, ye, x, y;
  logic [FB_ADDR_W-1:0] row_base, y_base;
  assign y_base = FB_ADDR_W'(y0) * WA;
  assign last = x == xe && y == ye;
  // reset state is the whole-buffer rectangle so a post-reset clear needs no load
  always_ff @(posedge pclk or posedge rst)
    if (rst) begin
      xs <= '0;
      xe <= XM;
      ye <= YM;
      x <= '0;
      y <= '0;
      row_base <= '0;
      addr <= '0;
    end else if (load) begin
      xs <= x0;
      xe <= x1;
      ye <= y1;
      x <= x0;
      y <= y0;
      row_base <= y_base;
      addr <= y_base + FB_ADDR_W'(x0);
    end else if (step) begin
      if (x == xe) begin
        x <= xs;
        y <= y + 1'b1;
        row_base <= row_base + WA;
        addr <= row_base + WA + FB_ADDR_W'(xs);
      end else begin
        x <= x + 1'b1;
        addr <= addr + 1'b1;
      end
    end
endmodule

// File: rtl/bg_fb_writer.sv
// bg_fb_writer: clear/rect-fill write agent for the background framebuffer; ports pclk, rst, bus (cmd_* in; cmd_ready, wr_*, busy, done, err out)
module bg_fb_writer #(
  parameter int FB_WIDTH = 400,
  parameter int FB_HEIGHT = 300,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter logic [3:0] CLEAR_COLOR = 4'h0
) (
  input logic         pclk,
  input logic         rst,
  bg_fb_writer_if.slave bus
);
  import bg_fb_writer_pkg::*;
  localparam logic [FB_COORD_W-1:0] XM = FB_COORD_W'(FB_WIDTH - 1);
  localparam logic [FB_COORD_W-1:0] YM = FB_COORD_W'(FB_HEIGHT - 1);
  logic [1:0] state;
  logic [FB_COORD_W-1:0] x1c, y1c;
  logic accept, bad, load, step, last;
  assign x1c = bus.cmd_x1 > XM ? XM : bus.cmd_x1;
  assign y1c = bus.cmd_y1 > YM ? YM : bus.cmd_y1;
  assign bad = bus.cmd_x0 > XM || bus.cmd_y0 > YM || bus.cmd_x0 > x1c || bus.cmd_y0 > y1c;
  assign accept = state == S_IDLE && bus.cmd_valid && bus.cmd_ready;
  assign load = accept && !bad;
  assign step = state != S_IDLE && bus.wr_en && !last;
  assign bus.busy = state != S_IDLE;
  fb_rect_scanner #(.W(FB_WIDTH), .H(FB_HEIGHT)) u_scan (
    .pclk(pclk),
    .rst(rst),
    .load(load),
    .step(step),
    .x0(bus.cmd_x0),
    .y0(bus.cmd_y0),
    .x1(x1c),
    .y1(y1c),
    .addr(bus.wr_addr),
    .last(last)
  );
  // CLEAR spends its first cycle raising wr_en; the scanner already points at address 0
  always_ff @(posedge pclk or posedge rst)
    if (rst) begin
      state <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      bus.cmd_ready <= 1'b0;
      bus.wr_en <= 1'b0;
      bus.wr_data <= '0;
      bus.done <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      bus.err <= 1'b0;
      if (state == S_IDLE) begin
        bus.cmd_ready <= 1'b1;
        if (accept) begin
          bus.err <= bad;
          if (!bad) begin
            state <= S_FILL;
            bus.cmd_ready <= 1'b0;
            bus.wr_en <= 1'b1;
            bus.wr_data <= bus.cmd_color;
          end
        end
      end else if (!bus.wr_en) begin
        bus.wr_en <= 1'b1;
        bus.wr_data <= CLEAR_COLOR;
      end else if (last) begin
        state <= S_IDLE;
        bus.wr_en <= 1'b0;
        bus.cmd_ready <= 1'b1;
        bus.done <= 1'b1;
      end
    end
endmodule

// File: tb/tb_bg_fb_writer.sv
// tb_bg_fb_writer: directed table-driven bench for bg_fb_writer
module tb_bg_fb_writer;
  typedef struct {
    logic [8:0] x0, y0, x1, y1;
    logic [3:0] c;
    bit bad;
    int nw, first, last;
  } vec_t;
  logic pclk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  vec_t v[9];
  bg_fb_writer_if a();
  bg_fb_writer_if b();
  bg_fb_writer #(.FB_WIDTH(400), .FB_HEIGHT(300), .CLEAR_ON_RESET(1'b0), .CLEAR_COLOR(4'h0)) dut_a (
    .pclk(pclk), .rst(rst), .bus(a));
  bg_fb_writer #(.FB_WIDTH(40), .FB_HEIGHT(30), .CLEAR_ON_RESET(1'b1), .CLEAR_COLOR(4'h5)) dut_b (
    .pclk(pclk), .rst(rst), .bus(b));
  always #5 pclk = ~pclk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  function automatic vec_t mk(int x0, y0, x1, y1, c, bad, nw, first, last);
    vec_t r;
    r.x0 = 9'(x0); r.y0 = 9'(y0); r.x1 = 9'(x1); r.y1 = 9'(y1); r.c = 4'(c);
    r.bad = bad != 0; r.nw = nw; r.first = first; r.last = last;
    return r;
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge pclk);
    #1;
  endtask
  task automatic run_a(input vec_t t);
    int n, ex, ey, xe, ye, first, last, wt;
    xe = t.x1 > 399 ? 399 : int'(t.x1);
    ye = t.y1 > 299 ? 299 : int'(t.y1);
    wt = 0;
    while (a.cmd_ready !== 1'b1 && wt < 20) begin tick(); wt++; end
    chk("ready_before", a.cmd_ready, 1);
    a.cmd_x0 = t.x0; a.cmd_y0 = t.y0; a.cmd_x1 = t.x1; a.cmd_y1 = t.y1; a.cmd_color = t.c;
    a.cmd_valid = 1'b1;
    tick();
    a.cmd_valid = 1'b0;
    a.cmd_x0 = 9'h1ff; a.cmd_y0 = 9'h0; a.cmd_x1 = 9'h0; a.cmd_y1 = 9'h1ff; a.cmd_color = ~t.c;
    n = 0; ex = t.x0; ey = t.y0; first = -1; last = -1;
    while (a.wr_en === 1'b1 && n < t.nw + 4) begin
      chk("fill_addr", a.wr_addr, ey * 400 + ex);
      chk("fill_data", a.wr_data, t.c);
      chk("fill_ready", a.cmd_ready, 0);
      chk("fill_busy", a.busy, 1);
      if (n == 0) first = int'(a.wr_addr);
      last = int'(a.wr_addr);
      n++;
      if (ex == xe) begin ex = t.x0; ey++; end else ex++;
      tick();
    end
    chk("n_writes", n, t.nw);
    chk("err_pulse", a.err, t.bad);
    chk("done_pulse", a.done, !t.bad);
    chk("ready_after", a.cmd_ready, 1);
    chk("busy_after", a.busy, 0);
    if (!t.bad) begin
      chk("first_addr", first, t.first);
      chk("last_addr", last, t.last);
    end
    tick();
    chk("pulse_width", a.done | a.err, 0);
  endtask
  initial begin
    v[0] = mk(10, 5, 11, 6, 4'hA, 0, 4, 2010, 2411);
    v[1] = mk(395, 299, 500, 299, 3, 0, 5, 119995, 119999);
    v[2] = mk(20, 0, 10, 0, 7, 1, 0, 0, 0);
    v[3] = mk(400, 0, 405, 0, 1, 1, 0, 0, 0);
    v[4] = mk(0, 0, 0, 0, 4'hF, 0, 1, 0, 0);
    v[5] = mk(3, 298, 4, 400, 9, 0, 4, 119203, 119604);
    v[6] = mk(0, 300, 5, 310, 2, 1, 0, 0, 0);
    v[7] = mk(5, 10, 6, 9, 2, 1, 0, 0, 0);
    v[8] = mk(398, 0, 511, 1, 6, 0, 4, 398, 799);
    a.cmd_valid = 1'b0; a.cmd_x0 = '0; a.cmd_y0 = '0; a.cmd_x1 = '0; a.cmd_y1 = '0; a.cmd_color = '0;
    b.cmd_valid = 1'b0; b.cmd_x0 = '0; b.cmd_y0 = '0; b.cmd_x1 = '0; b.cmd_y1 = '0; b.cmd_color = '0;
    #12;
    chk("rst_a_ready", a.cmd_ready, 0);
    chk("rst_a_wr_en", a.wr_en, 0);
    chk("rst_a_addr", a.wr_addr, 0);
    chk("rst_a_data", a.wr_data, 0);
    chk("rst_a_done", a.done, 0);
    chk("rst_a_err", a.err, 0);
    chk("rst_a_busy", a.busy, 0);
    chk("rst_b_busy", b.busy, 1);
    chk("rst_b_ready", b.cmd_ready, 0);
    chk("rst_b_wr_en", b.wr_en, 0);
    rst = 1'b0;
    tick();
    chk("a_ready_first_edge", a.cmd_ready, 1);
    chk("a_busy_idle", a.busy, 0);
    for (int i = 0; i < 1200; i++) begin
      chk("clr_wr_en", b.wr_en, 1);
      chk("clr_addr", b.wr_addr, i);
      chk("clr_data", b.wr_data, 5);
      chk("clr_ready", b.cmd_ready, 0);
      tick();
    end
    chk("clr_end_wr_en", b.wr_en, 0);
    chk("clr_done", b.done, 1);
    chk("clr_done_ready", b.cmd_ready, 1);
    chk("clr_end_busy", b.busy, 0);
    tick();
    chk("clr_done_width", b.done, 0);
    for (int i = 0; i < 9; i++) run_a(v[i]);
    a.cmd_x0 = 9'd1; a.cmd_y0 = 9'd1; a.cmd_x1 = 9'd1; a.cmd_y1 = 9'd1; a.cmd_color = 4'h4;
    a.cmd_valid = 1'b1;
    tick();
    a.cmd_x0 = 9'd2; a.cmd_y0 = 9'd1; a.cmd_x1 = 9'd2; a.cmd_y1 = 9'd1; a.cmd_color = 4'h5;
    chk("b2b_w1_en", a.wr_en, 1);
    chk("b2b_w1_addr", a.wr_addr, 401);
    chk("b2b_w1_data", a.wr_data, 4);
    tick();
    chk("b2b_gap_en", a.wr_en, 0);
    chk("b2b_gap_done", a.done, 1);
    chk("b2b_gap_ready", a.cmd_ready, 1);
    tick();
    a.cmd_valid = 1'b0;
    chk("b2b_w2_en", a.wr_en, 1);
    chk("b2b_w2_addr", a.wr_addr, 402);
    chk("b2b_w2_data", a.wr_data, 5);
    tick();
    chk("b2b_done2", a.done, 1);
    chk("b2b_end_en", a.wr_en, 0);
    tick();
    chk("b2b_no_third", a.wr_en, 0);
    chk("b2b_idle_ready", a.cmd_ready, 1);
    b.cmd_x0 = 9'd2; b.cmd_y0 = 9'd3; b.cmd_x1 = 9'd20; b.cmd_y1 = 9'd20; b.cmd_color = 4'h9;
    b.cmd_valid = 1'b1;
    tick();
    b.cmd_valid = 1'b0;
    for (int i = 0; i < 37; i++) begin
      chk("mid_fill_en", b.wr_en, 1);
      chk("mid_fill_addr", b.wr_addr, (3 + i / 19) * 40 + 2 + i % 19);
      chk("mid_fill_data", b.wr_data, 9);
      tick();
    end
    chk("mid_w38_en", b.wr_en, 1);
    #1 rst = 1'b1;
    #1;
    chk("async_wr_en", b.wr_en, 0);
    chk("async_addr", b.wr_addr, 0);
    chk("async_data", b.wr_data, 0);
    chk("async_ready", b.cmd_ready, 0);
    chk("async_busy", b.busy, 1);
    #2 rst = 1'b0;
    tick();
    chk("reclr_en", b.wr_en, 1);
    chk("reclr_addr0", b.wr_addr, 0);
    chk("reclr_data", b.wr_data, 5);
    tick();
    chk("reclr_addr1", b.wr_addr, 1);
    chk("reclr_busy", b.busy, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
